// File: rtl/wb_writeback_unit.sv
// Register-file write port: arbitrates ALU and load results, buffers colliding loads,
// tracks pending loads for decode stalls. Define WB_BYPASS_EN for forwarding outputs.
module wb_writeback_unit #(
  parameter int LD_DEPTH = 2,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1,
  input  logic            rs1_valid,
  input  logic [4:0]      rs2,
  input  logic            rs2_valid,
  input  logic [4:0]      dst,
  input  logic            dst_valid,
  output logic            stall,
  output logic            wr_en,
  output logic [4:0]      wr_rd,
  output logic [XLEN-1:0] wr_data
`ifdef WB_BYPASS_EN
  ,
  output logic            fwd_rs1_hit,
  output logic            fwd_rs2_hit,
  output logic [XLEN-1:0] fwd_rs1_data,
  output logic [XLEN-1:0] fwd_rs2_data
`endif
);

  localparam int          AW       = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(LD_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [4:0]      fifo_rd   [LD_DEPTH];
  logic [XLEN-1:0] fifo_data [LD_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fifo_cnt;
  logic            fifo_empty, ld_acc, push, pop;

  logic            sel_vld_p0, sel_is_ld_p0;
  logic [4:0]      sel_rd_p0;
  logic [XLEN-1:0] sel_data_p0;

  logic [31:0]     busy, busy_nxt;

  assign fifo_empty = (fifo_cnt == '0);
  assign ld_ready   = (fifo_cnt != FULL_CNT);
  assign ld_acc     = ld_valid && ld_ready;

  // Stage p0: pick this cycle's write source (ALU > FIFO head > direct load)
  always_comb begin
    push         = 1'b0;
    pop          = 1'b0;
    sel_vld_p0   = 1'b0;
    sel_is_ld_p0 = 1'b0;
    sel_rd_p0    = alu_rd;
    sel_data_p0  = alu_data;
    if (alu_valid) begin
      sel_vld_p0 = 1'b1;
      push       = ld_acc;
    end else if (!fifo_empty) begin
      sel_vld_p0   = 1'b1;
      sel_is_ld_p0 = 1'b1;
      sel_rd_p0    = fifo_rd[rd_ptr];
      sel_data_p0  = fifo_data[rd_ptr];
      pop          = 1'b1;
      push         = ld_acc;
    end else if (ld_acc) begin
      sel_vld_p0   = 1'b1;
      sel_is_ld_p0 = 1'b1;
      sel_rd_p0    = ld_rd;
      sel_data_p0  = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Issue after clear so a same-cycle re-issue keeps the register pending
  always_comb begin
    busy_nxt = busy;
    if (sel_vld_p0 && sel_is_ld_p0) busy_nxt[sel_rd_p0] = 1'b0;
    if (iss_valid)                  busy_nxt[iss_rd]    = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign stall = (rs1_valid && busy[rs1]) || (rs2_valid && busy[rs2]) ||
                 (dst_valid && busy[dst]);

  // Stage p1: registered write port; rd==0 results are consumed without a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_rd   <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= sel_vld_p0 && (sel_rd_p0 != 5'd0);
      if (sel_vld_p0 && (sel_rd_p0 != 5'd0)) begin
        wr_rd   <= sel_rd_p0;
        wr_data <= sel_data_p0;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_rs1_hit  = wr_en && (wr_rd == rs1) && (rs1 != 5'd0);
  assign fwd_rs2_hit  = wr_en && (wr_rd == rs2) && (rs2 != 5'd0);
  assign fwd_rs1_data = wr_data;
  assign fwd_rs2_data = wr_data;
`endif

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Self-checking bench for wb_writeback_unit: scenario tasks plus a write-order scoreboard.
module tb_wb_writeback_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            ld_valid = 1'b0;
  logic            ld_ready;
  logic [4:0]      ld_rd = '0;
  logic [XLEN-1:0] ld_data = '0;
  logic            iss_valid = 1'b0;
  logic [4:0]      iss_rd = '0;
  logic [4:0]      rs1 = '0, rs2 = '0, dst = '0;
  logic            rs1_valid = 1'b0, rs2_valid = 1'b0, dst_valid = 1'b0;
  logic            stall;
  logic            wr_en;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data;
`ifdef WB_BYPASS_EN
  logic            fwd_rs1_hit, fwd_rs2_hit;
  logic [XLEN-1:0] fwd_rs1_data, fwd_rs2_data;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  wb_writeback_unit #(.LD_DEPTH(2), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1(rs1), .rs1_valid(rs1_valid), .rs2(rs2), .rs2_valid(rs2_valid),
    .dst(dst), .dst_valid(dst_valid), .stall(stall),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data)
`ifdef WB_BYPASS_EN
    , .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data)
`endif
  );

  always #5 clk = ~clk;

  // Every register-file write must match the next expected entry, in order
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n && wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", wr_rd, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_rd !== e.rd || wr_data !== e.data) begin
          errors++;
          $display("FAIL write_order: got rd=%0d data=%h, expected rd=%0d data=%h",
                   wr_rd, wr_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1111_2222;
    rs1 = 5'd5; rs1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({wr_en, wr_rd, wr_data, ld_ready, stall} !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_state: got wr_en=%b wr_rd=%0d wr_data=%h ld_ready=%b stall=%b, expected 0 0 0 1 0",
                 wr_en, wr_rd, wr_data, ld_ready, stall);
      end
    end
    alu_valid = 1'b0; rs1_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got wr_en=%b, expected 0", wr_en);
    end
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    exp_q.push_back({5'd5, 32'hDEAD_BEEF});
    tick();
    alu_valid = 1'b0;
    checks++;
    if ({wr_en, wr_rd, wr_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL alu_write: got wr_en=%b wr_rd=%0d wr_data=%h, expected 1 5 deadbeef", wr_en, wr_rd, wr_data);
    end
    tick();
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL alu_single: got wr_en=%b, expected 0", wr_en);
    end
  endtask

  task automatic test_collide();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0333;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h0000_0777;
    exp_q.push_back({5'd3, 32'h0000_0333});
    exp_q.push_back({5'd7, 32'h0000_0777});
    tick();
    alu_valid = 1'b0; ld_valid = 1'b0;
    checks++;
    if ({wr_en, wr_rd} !== {1'b1, 5'd3}) begin
      errors++;
      $display("FAIL collide_alu_first: got wr_en=%b wr_rd=%0d, expected 1 3", wr_en, wr_rd);
    end
    tick();
    checks++;
    if ({wr_en, wr_rd, wr_data} !== {1'b1, 5'd7, 32'h0000_0777}) begin
      errors++;
      $display("FAIL collide_load_second: got wr_en=%b wr_rd=%0d wr_data=%h, expected 1 7 00000777",
               wr_en, wr_rd, wr_data);
    end
    tick();
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL collide_idle: got wr_en=%b, expected 0", wr_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_rdy;
    logic       acc;
    int         li;
    exp_rdy = 8'hF3;
    li = 0;
    for (int i = 0; i < 3; i++) exp_q.push_back({5'(10 + i), 32'hB000_0000 + 32'(i)});
    for (int i = 0; i < 3; i++) exp_q.push_back({5'(20 + i), 32'hA000_0000 + 32'(i)});
    for (int c = 0; c < 8; c++) begin
      alu_valid = (c < 3); alu_rd = 5'(10 + c); alu_data = 32'hB000_0000 + 32'(c);
      ld_valid = (li < 3); ld_rd = 5'(20 + li); ld_data = 32'hA000_0000 + 32'(li);
      checks++;
      if (ld_ready !== exp_rdy[c]) begin
        errors++;
        $display("FAIL b2b_ld_ready[%0d]: got %b, expected %b", c, ld_ready, exp_rdy[c]);
      end
      acc = ld_valid && ld_ready;
      tick();
      if (acc) li++;
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    checks++;
    if (li != 3 || ld_ready !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got accepted=%0d ld_ready=%b pending=%0d, expected 3 1 0",
               li, ld_ready, exp_q.size());
    end
  endtask

  task automatic test_scoreboard();
    rs1 = 5'd9; rs1_valid = 1'b1; iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL sb_before_set: got stall=%b, expected 0", stall); end
    tick();
    iss_valid = 1'b0;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL sb_rs1: got stall=%b, expected 1", stall); end
    rs1_valid = 1'b0; rs2 = 5'd9; rs2_valid = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL sb_rs2: got stall=%b, expected 1", stall); end
    rs2_valid = 1'b0; dst = 5'd9; dst_valid = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL sb_dst: got stall=%b, expected 1", stall); end
    dst_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL sb_no_valid: got stall=%b, expected 0", stall); end
    tick();
    rs1 = 5'd10; rs1_valid = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL sb_other_reg: got stall=%b, expected 0", stall); end
    rs1 = 5'd9;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0000_0909;
    exp_q.push_back({5'd9, 32'h0000_0909});
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL sb_pending: got stall=%b, expected 1", stall); end
    tick();
    ld_valid = 1'b0;
    checks++;
    if ({stall, wr_en, wr_rd} !== {1'b0, 1'b1, 5'd9}) begin
      errors++;
      $display("FAIL sb_clear: got stall=%b wr_en=%b wr_rd=%0d, expected 0 1 9", stall, wr_en, wr_rd);
    end
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0000_0999;
    exp_q.push_back({5'd9, 32'h0000_0999});
    tick();
    iss_valid = 1'b0; ld_valid = 1'b0;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got stall=%b, expected 1", stall); end
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0000_0AAA;
    exp_q.push_back({5'd9, 32'h0000_0AAA});
    tick();
    ld_valid = 1'b0;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL sb_reclear: got stall=%b, expected 0", stall); end
    iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
    tick();
    iss_valid = 1'b0;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL sb_x0: got stall=%b, expected 0", stall); end
    rs1_valid = 1'b0;
  endtask

  task automatic test_rd_zero();
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h0000_1234;
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready_before: got %b, expected 1", ld_ready); end
    tick();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_5678;
    checks++;
    if ({wr_en, ld_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rd0_load: got wr_en=%b ld_ready=%b, expected 0 1", wr_en, ld_ready);
    end
    tick();
    alu_valid = 1'b0;
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL rd0_alu: got wr_en=%b, expected 0", wr_en); end
    tick();
  endtask

  task automatic test_mid_reset();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_0001;
    ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h0000_0666;
    iss_valid = 1'b1; iss_rd = 5'd4; rs1 = 5'd4; rs1_valid = 1'b1;
    exp_q.push_back({5'd1, 32'h0000_0001});
    tick();
    alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
    checks++;
    if ({wr_en, stall, ld_ready} !== 3'b111) begin
      errors++;
      $display("FAIL midrst_pre: got wr_en=%b stall=%b ld_ready=%b, expected 1 1 1", wr_en, stall, ld_ready);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, stall, ld_ready} !== 3'b001) begin
      errors++;
      $display("FAIL midrst_async: got wr_en=%b stall=%b ld_ready=%b, expected 0 0 1", wr_en, stall, ld_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({wr_en, stall} !== 2'b00) begin
        errors++;
        $display("FAIL midrst_after[%0d]: got wr_en=%b stall=%b, expected 0 0", i, wr_en, stall);
      end
    end
    rs1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_collide();
    test_back_to_back();
    test_scoreboard();
    test_rd_zero();
    test_mid_reset();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_writes: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
